// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signals of the ALU operation sequencer.
// The master modport is the sequencer side; slave is the surrounding control unit and ALU.
interface alu_op_sequencer_if #(
   parameter int DW  = 32,
   parameter int OPW = 5
);
   logic           req_valid;
   logic           req_ready;
   logic [OPW-1:0] req_op;
   logic [DW-1:0]  req_a;
   logic [DW-1:0]  req_b;
   logic [OPW-1:0] alu_op;
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [DW-1:0]  alu_c;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [DW-1:0]  rsp_result;
   logic           rsp_err;
   logic           busy;

   modport master (
      input  req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
      output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_err, busy
   );

   modport slave (
      output req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
      input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_err, busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller between the instruction control unit and a shifter-less ALU:
// arithmetic/logic ops go through the ALU, shifts/rotates are done one bit per cycle in Z.
module alu_op_sequencer #(
   parameter int DW          = 32,
   parameter int OPW         = 5,
   parameter int MULDIV_WAIT = 2
) (
   input  logic                clock,
   input  logic                clear,
   alu_op_sequencer_if.master  io
);
   localparam int CW = $clog2(DW);
   localparam int WW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(5);
   localparam logic [OPW-1:0] OP_SHRA = OPW'(6);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(7);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(8);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(9);
   localparam logic [OPW-1:0] OP_AND  = OPW'(10);
   localparam logic [OPW-1:0] OP_OR   = OPW'(11);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(18);

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

   function automatic logic is_shift(input logic [OPW-1:0] op);
      return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL) ||
             (op == OP_ROR) || (op == OP_ROL);
   endfunction

   function automatic logic is_muldiv(input logic [OPW-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_legal(input logic [OPW-1:0] op);
      return is_shift(op) || is_muldiv(op) ||
             (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_NEG) || (op == OP_NOT);
   endfunction

   state_t         state_q, state_d;
   logic [DW-1:0]  y_q, y_d;
   logic [DW-1:0]  b_q, b_d;
   logic [DW-1:0]  z_q, z_d;
   logic [OPW-1:0] op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           err_q, err_d;
   logic           req_ready_q, req_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           busy_q, busy_d;
   logic [OPW-1:0] alu_op_q, alu_op_d;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      y_d      = y_q;
      b_d      = b_q;
      z_d      = z_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (io.req_valid) begin
               y_d    = io.req_a;
               b_d    = io.req_b;
               op_d   = io.req_op;
               wait_d = '0;
               if (!is_legal(io.req_op) || (io.req_op == OP_DIV && io.req_b == '0)) begin
                  z_d     = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (is_shift(io.req_op)) begin
                  z_d     = io.req_a;
                  err_d   = 1'b0;
                  cnt_d   = io.req_b[CW-1:0];
                  state_d = (io.req_b[CW-1:0] == '0) ? DONE : SHIFT;
               end else begin
                  err_d   = 1'b0;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            // MUL/DIV hold the ALU inputs for MULDIV_WAIT extra cycles before capture.
            if (is_muldiv(op_q) && wait_q != WW'(MULDIV_WAIT)) begin
               wait_d = wait_q + WW'(1);
            end else begin
               z_d     = io.alu_c;
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         SHIFT: begin
            unique case (op_q)
               OP_SHR:  z_d = {1'b0, z_q[DW-1:1]};
               OP_SHRA: z_d = {z_q[DW-1], z_q[DW-1:1]};
               OP_SHL:  z_d = {z_q[DW-2:0], 1'b0};
               OP_ROR:  z_d = {z_q[0], z_q[DW-1:1]};
               default: z_d = {z_q[DW-2:0], z_q[DW-1]};
            endcase
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            if (io.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Handshake and ALU-select outputs are registered from the next state.
      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      rsp_valid_d = (state_d == DONE);
      alu_op_d    = (state_d == EXEC) ? op_d : '0;
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (clear) begin
         state_q     <= IDLE;
         y_q         <= '0;
         b_q         <= '0;
         z_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         alu_op_q    <= '0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         b_q         <= b_d;
         z_q         <= z_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         alu_op_q    <= alu_op_d;
      end
   end

   assign io.req_ready  = req_ready_q;
   assign io.busy       = busy_q;
   assign io.rsp_valid  = rsp_valid_q;
   assign io.rsp_result = z_q;
   assign io.rsp_err    = err_q;
   assign io.alu_op     = alu_op_q;
   assign io.alu_a      = y_q;
   assign io.alu_b      = b_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_op_sequencer;
   localparam int DW = 32;
   localparam int OPW = 5;
   localparam int MULDIV_WAIT = 2;

   logic clock;
   logic clear;
   int   vectors;
   int   miscompares;

   alu_op_sequencer_if #(.DW(DW), .OPW(OPW)) bus ();

   alu_op_sequencer #(.DW(DW), .OPW(OPW), .MULDIV_WAIT(MULDIV_WAIT)) dut (
      .clock (clock),
      .clear (clear),
      .io    (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Combinational ALU model; unknown selects produce an obvious marker value.
   always_comb begin
      case (bus.alu_op)
         5'd3:    bus.alu_c = bus.alu_a + bus.alu_b;
         5'd4:    bus.alu_c = bus.alu_a - bus.alu_b;
         5'd10:   bus.alu_c = bus.alu_a & bus.alu_b;
         5'd11:   bus.alu_c = bus.alu_a | bus.alu_b;
         5'd15:   bus.alu_c = bus.alu_a * bus.alu_b;
         5'd16:   bus.alu_c = (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : 32'hBAD0_0000;
         5'd17:   bus.alu_c = -bus.alu_a;
         5'd18:   bus.alu_c = ~bus.alu_a;
         default: bus.alu_c = 32'hDEAD_BEEF;
      endcase
   end

   // ---------------- reference model ----------------
   function automatic bit m_legal(input logic [4:0] op);
      int legal_list[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
      foreach (legal_list[i]) if (int'(op) == legal_list[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_shift(input logic [4:0] op);
      return int'(op) >= 5 && int'(op) <= 9;
   endfunction

   function automatic bit m_err(input logic [4:0] op, input logic [31:0] b);
      return !m_legal(op) || (op == 5'd16 && b == 0);
   endfunction

   function automatic logic [31:0] m_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      logic signed [31:0] sa;
      logic [63:0] prod;
      n = int'(b % 32);
      sa = a;
      prod = 64'(a) * 64'(b);
      if (m_err(op, b)) return 32'h0;
      case (int'(op))
         3:  return a + b;
         4:  return a - b;
         5:  return a >> n;
         6:  return sa >>> n;
         7:  return a << n;
         8:  return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
         9:  return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
         10: return a & b;
         11: return a | b;
         15: return prod[31:0];
         16: return a / b;
         17: return 32'h0 - a;
         default: return ~a;
      endcase
   endfunction

   function automatic int m_latency(input logic [4:0] op, input logic [31:0] b);
      if (m_err(op, b)) return 1;
      if (m_shift(op)) return (b % 32 == 0) ? 1 : int'(b % 32) + 1;
      if (op == 5'd15 || op == 5'd16) return 2 + MULDIV_WAIT;
      return 2;
   endfunction

   function automatic int m_alu_cycles(input logic [4:0] op, input logic [31:0] b);
      if (m_err(op, b) || m_shift(op)) return 0;
      if (op == 5'd15 || op == 5'd16) return 1 + MULDIV_WAIT;
      return 1;
   endfunction

   // ---------------- generic transaction ----------------
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string name);
      int n;
      int lat;
      int alu_cycles;
      int bad_sel;
      logic [31:0] exp_res;
      logic        exp_err;
      exp_res = m_result(op, a, b);
      exp_err = m_err(op, b);

      @(negedge clock);
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s accept_wait: req_ready=%b required 1", name, bus.req_ready);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = 1'b0;
      @(posedge clock);
      #1 bus.req_valid = 1'b0;

      lat = 0;
      alu_cycles = 0;
      bad_sel = 0;
      while (lat < 200) begin
         @(negedge clock);
         lat++;
         if (bus.alu_op !== 5'd0) begin
            alu_cycles++;
            if (bus.alu_op !== op) bad_sel++;
         end
         if (bus.rsp_valid === 1'b1) break;
      end

      vectors++;
      if (lat !== m_latency(op, b)) begin
         miscompares++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, m_latency(op, b));
      end
      vectors++;
      if (bus.rsp_result !== exp_res) begin
         miscompares++;
         $display("FAIL %s result: got %h required %h", name, bus.rsp_result, exp_res);
      end
      vectors++;
      if (bus.rsp_err !== exp_err) begin
         miscompares++;
         $display("FAIL %s err: got %b required %b", name, bus.rsp_err, exp_err);
      end
      vectors++;
      if (alu_cycles !== m_alu_cycles(op, b) || bad_sel !== 0) begin
         miscompares++;
         $display("FAIL %s alu_drive: cycles %0d (wrong select %0d) required %0d",
                  name, alu_cycles, bad_sel, m_alu_cycles(op, b));
      end

      // Hold the response; a competing request must be ignored.
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1;
         bus.req_op    = 5'd3;
         bus.req_a     = $urandom;
         bus.req_b     = $urandom;
         @(negedge clock);
         vectors++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp_res || bus.rsp_err !== exp_err ||
             bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s hold[%0d]: valid=%b result=%h err=%b ready=%b busy=%b required 1/%h/%b/0/1",
                     name, i, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready, bus.busy,
                     exp_res, exp_err);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s release: valid=%b ready=%b busy=%b required 0/1/0",
                  name, bus.rsp_valid, bus.req_ready, bus.busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic apply_clear();
      clear = 1'b1;
      repeat (2) @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      apply_clear();
      vectors++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_err !== 1'b0 || bus.alu_op !== 5'd0 || bus.rsp_result !== 32'h0 ||
          bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: ready=%b busy=%b valid=%b err=%b alu_op=%h z=%h y=%h b=%h required 1/0/0/0/0/0/0/0",
                  bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err, bus.alu_op,
                  bus.rsp_result, bus.alu_a, bus.alu_b);
      end
   endtask

   task automatic test_alu_ops();
      do_op(5'd3,  32'd5,   32'd7,  0, "add_5_7");
      do_op(5'd16, 32'd100, 32'd7,  0, "div_100_7");
      do_op(5'd15, 32'h0001_0000, 32'h0001_0000, 0, "mul_overflow");
      do_op(5'd17, 32'd1,   32'd0,  1, "neg_1");
      do_op(5'd18, 32'h0F0F_0000, 32'd0, 0, "not");
   endtask

   task automatic test_shifts();
      do_op(5'd6, 32'h8000_0000, 32'd4,  0, "shra_4");
      do_op(5'd9, 32'h8000_0001, 32'd1,  0, "rol_1");
      do_op(5'd7, 32'h1234_5678, 32'd0,  0, "shl_0");
      do_op(5'd8, 32'h0000_00F1, 32'd31, 0, "ror_31");
      do_op(5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFE3, 0, "shr_count_bits");
   endtask

   task automatic test_errors();
      do_op(5'd16, 32'd100, 32'd0, 0, "div_by_zero");
      do_op(5'h1F, 32'd1,   32'd2, 0, "illegal_1f");
      do_op(5'd0,  32'd1,   32'd2, 0, "illegal_0");
   endtask

   task automatic test_back_to_back();
      do_op(5'd4, 32'd20, 32'd3, 5, "stall_sub");
      do_op(5'd11, 32'hF000_0000, 32'h0000_000F, 0, "or_after_stall");
   endtask

   task automatic test_clear_mid_op();
      int n;
      @(negedge clock);
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = 5'd7;
      bus.req_a     = 32'hABCD_1234;
      bus.req_b     = 32'd20;
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      repeat (3) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.rsp_result !== 32'h0 || bus.alu_a !== 32'h0) begin
         miscompares++;
         $display("FAIL clear_mid_shift: valid=%b busy=%b ready=%b z=%h y=%h required 0/0/1/0/0",
                  bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_result, bus.alu_a);
      end
      do_op(5'd4, 32'd9, 32'd10, 0, "sub_after_clear");
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int pick;
      int legal_list[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
      for (int i = 0; i < 80; i++) begin
         pick = int'($urandom_range(0, 15));
         op = (pick < 13) ? 5'(legal_list[pick]) : 5'($urandom_range(19, 31));
         a  = $urandom;
         b  = $urandom;
         if (op == 5'd16) begin
            case ($urandom_range(0, 3))
               0: b = 32'd0;
               1: b = 32'($urandom_range(1, 1000));
               default: b = $urandom;
            endcase
         end
         if (m_shift(op) && $urandom_range(0, 5) == 0) b = b & 32'hFFFF_FFE0;
         do_op(op, a, b, int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors       = 0;
      miscompares   = 0;
      clear         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;

      test_reset();
      test_alu_ops();
      test_shifts();
      test_errors();
      test_back_to_back();
      test_clear_mid_op();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
